t08_irq_ctrl: RTL and testbench

//  Multi-channel interrupt front end; generalises the single touchscreen_interrupt input of t08_top.

---
 rtl/t08_irq_pkg.sv | 18 +
 rtl/t08_irq_if.sv | 34 +++
 rtl/t08_irq_chan.sv | 82 ++++++++
 rtl/t08_irq_ctrl.sv | 81 ++++++++
 tb/tb_t08_irq_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/t08_irq_pkg.sv
// Shared types and default sizing for the multi-channel interrupt front end.
package t08_irq_pkg;

    typedef enum logic {
        IRQ_EDGE  = 1'b0,
        IRQ_LEVEL = 1'b1
    } t08_irq_mode_e;

    localparam int T08_IRQ_NUM_CH          = 4;
    localparam int T08_IRQ_SYNC_STAGES     = 2;
    localparam int T08_IRQ_DEBOUNCE_CYCLES = 4;

    // Width of a channel index; a single channel still gets a 1-bit id.
    function automatic int t08_irq_id_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/t08_irq_if.sv
// CPU-side bundle of the interrupt controller: raw lines, configuration,
// acknowledge/clear strobes and the request/status outputs.
interface t08_irq_if
    import t08_irq_pkg::*;
#(
    parameter int NUM_CH = T08_IRQ_NUM_CH,
    parameter int IDW    = t08_irq_id_width(NUM_CH)
) ();

    logic [NUM_CH-1:0] irq_raw_i;
    logic [NUM_CH-1:0] cfg_active_low_i;
    logic [NUM_CH-1:0] cfg_level_mode_i;
    logic [NUM_CH-1:0] cfg_en_i;
    logic              ack_i;
    logic [IDW-1:0]    ack_id_i;
    logic              ovf_clr_i;
    logic              irq_o;
    logic [IDW-1:0]    irq_id_o;
    logic [NUM_CH-1:0] pending_o;
    logic [NUM_CH-1:0] overflow_o;

    modport master (
        output irq_raw_i, cfg_active_low_i, cfg_level_mode_i, cfg_en_i,
        output ack_i, ack_id_i, ovf_clr_i,
        input  irq_o, irq_id_o, pending_o, overflow_o
    );

    modport slave (
        input  irq_raw_i, cfg_active_low_i, cfg_level_mode_i, cfg_en_i,
        input  ack_i, ack_id_i, ovf_clr_i,
        output irq_o, irq_id_o, pending_o, overflow_o
    );

endinterface

// File: rtl/t08_irq_chan.sv
// One interrupt channel: synchroniser, debounce with power-up arming and
// edge/level event detection. The event output is registered.
module t08_irq_chan
    import t08_irq_pkg::*;
#(
    parameter int SYNC_STAGES     = T08_IRQ_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = T08_IRQ_DEBOUNCE_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          raw_line,
    input  logic          active_low,
    input  t08_irq_mode_e mode,
    output logic          irq_event
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   prev_q;
    logic                   armed_q;
    logic                   armed_d;
    logic                   event_q;
    logic                   norm;
    logic                   accept;

    assign norm   = sync_q[SYNC_STAGES-1] ^ active_low;
    assign accept = (DEBOUNCE_CYCLES == 0) || (cnt_q == CNT_LAST);

    // Until armed, the counter simply times out after reset and the first
    // acceptance adopts whatever level the line has settled to, so an idle
    // active-low line never looks like a fresh assertion.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        armed_d  = armed_q;
        if (!armed_q) begin
            if (accept) begin
                stable_d = norm;
                armed_d  = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (norm == stable_q) begin
            cnt_d = '0;
        end else if (accept) begin
            stable_d = norm;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // prev_q follows the newly adopted level on the arming cycle so that
    // arming cannot be mistaken for a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            event_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_line};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            prev_q   <= armed_q ? stable_q : stable_d;
            event_q  <= armed_q & stable_q & ((mode == IRQ_LEVEL) | ~prev_q);
        end
    end

    assign irq_event = event_q;

endmodule

// File: rtl/t08_irq_ctrl.sv
// Multi-channel interrupt controller: per-channel front ends, sticky pending
// and overflow flags, acknowledge decode and fixed lowest-index priority.
module t08_irq_ctrl
    import t08_irq_pkg::*;
#(
    parameter int NUM_CH          = T08_IRQ_NUM_CH,
    parameter int SYNC_STAGES     = T08_IRQ_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = T08_IRQ_DEBOUNCE_CYCLES
) (
    input  logic     clk,
    input  logic     rst,
    t08_irq_if.slave bus
);

    localparam int IDW = t08_irq_id_width(NUM_CH);

    logic [NUM_CH-1:0] chan_event;
    logic [NUM_CH-1:0] ack_hit;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] overflow_q;
    logic [NUM_CH-1:0] overflow_d;
    logic [NUM_CH-1:0] active;
    logic [IDW-1:0]    win_id;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        t08_irq_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .raw_line   (bus.irq_raw_i[g]),
            .active_low (bus.cfg_active_low_i[g]),
            .mode       (t08_irq_mode_e'(bus.cfg_level_mode_i[g])),
            .irq_event  (chan_event[g])
        );
    end

    // Ids at or beyond NUM_CH match no channel and are silently ignored.
    always_comb begin
        ack_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ack_hit[c] = bus.ack_i && (bus.ack_id_i == IDW'(c));
        end
    end

    // An edge event coinciding with its ack keeps the channel pending; a level
    // channel is always asserting, so there the ack wins for one cycle and
    // the next event re-sets it. A fresh overflow beats the clear strobe.
    always_comb begin
        pending_d  = (pending_q & ~ack_hit) | (chan_event & ~(ack_hit & bus.cfg_level_mode_i));
        overflow_d = (bus.ovf_clr_i ? '0 : overflow_q) | (chan_event & pending_q & ~ack_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        active = pending_q & bus.cfg_en_i;
        win_id = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (active[c]) begin
                win_id = IDW'(c);
            end
        end
    end

    assign bus.irq_o      = |active;
    assign bus.irq_id_o   = win_id;
    assign bus.pending_o  = pending_q;
    assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_t08_irq_ctrl.sv
// Randomised scoreboard bench for t08_irq_ctrl against a cycle-level
// behavioural model built from delay lines and run-length debounce counting.
module tb_t08_irq_ctrl;
    import t08_irq_pkg::*;

    localparam int NUM_CH          = 4;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int IDW             = 2;
    localparam int ARM_EDGE        = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    t08_irq_if #(.NUM_CH(NUM_CH), .IDW(IDW)) bus ();

    t08_irq_ctrl #(
        .NUM_CH          (NUM_CH),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH-1:0] pending;
        logic [NUM_CH-1:0] overflow;
        logic              irq;
        logic [IDW-1:0]    id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [NUM_CH-1:0] line_dly[$];
    logic [NUM_CH-1:0] evt_dly[$];
    logic [NUM_CH-1:0] m_stable;
    logic [NUM_CH-1:0] m_armed;
    logic [NUM_CH-1:0] m_pend;
    logic [NUM_CH-1:0] m_ovf;
    int                m_run[NUM_CH];
    int                edge_n;
    int                hold_left[NUM_CH];
    bit                quiet;

    function automatic logic [IDW-1:0] lowest(input logic [NUM_CH-1:0] v);
        int c = 0;
        while (c < NUM_CH && !v[c]) c++;
        return (c < NUM_CH) ? IDW'(c) : '0;
    endfunction

    task automatic modelReset();
        line_dly.delete();
        evt_dly.delete();
        for (int i = 0; i < SYNC_STAGES; i++) line_dly.push_back('0);
        evt_dly.push_back('0);
        evt_dly.push_back('0);
        m_stable = '0;
        m_armed  = '0;
        m_pend   = '0;
        m_ovf    = '0;
        for (int c = 0; c < NUM_CH; c++) m_run[c] = 0;
        edge_n = 0;
    endtask

    // A line seen SYNC_STAGES edges late is accepted after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; its event reaches pending two edges later.
    task automatic modelStep();
        logic [NUM_CH-1:0] seen, due, src, nxt_pend, nxt_ovf;
        due  = evt_dly.pop_front();
        seen = line_dly.pop_front();
        line_dly.push_back(bus.irq_raw_i);
        src = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            logic n, rose, hit;
            n    = seen[c] ^ bus.cfg_active_low_i[c];
            rose = 1'b0;
            if (!m_armed[c]) begin
                if (edge_n == ARM_EDGE) begin
                    m_stable[c] = n;
                    m_armed[c]  = 1'b1;
                    m_run[c]    = 0;
                end
            end else if (n == m_stable[c]) begin
                m_run[c] = 0;
            end else begin
                m_run[c]++;
                if (m_run[c] >= DEBOUNCE_CYCLES) begin
                    rose        = n;
                    m_stable[c] = n;
                    m_run[c]    = 0;
                end
            end
            src[c] = bus.cfg_level_mode_i[c] ? (m_armed[c] & m_stable[c]) : rose;
            hit = bus.ack_i && (int'(bus.ack_id_i) == c);
            nxt_ovf[c] = (bus.ovf_clr_i ? 1'b0 : m_ovf[c]) | (due[c] & m_pend[c] & !hit);
            if (bus.cfg_level_mode_i[c]) nxt_pend[c] = hit ? 1'b0 : (due[c] | m_pend[c]);
            else                         nxt_pend[c] = due[c] ? 1'b1 : (hit ? 1'b0 : m_pend[c]);
        end
        evt_dly.push_back(src);
        m_pend = nxt_pend;
        m_ovf  = nxt_ovf;
        edge_n++;
    endtask

    task automatic applyStimulus();
        logic [NUM_CH-1:0] raw;
        int idx;
        if (quiet) begin
            bus.ack_i     = 1'b0;
            bus.ovf_clr_i = 1'b0;
            return;
        end
        raw = bus.irq_raw_i;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hold_left[c] == 0) begin
                raw[c] = ~raw[c];
                hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                            : int'($urandom_range(6, 30));
            end else begin
                hold_left[c]--;
            end
        end
        bus.irq_raw_i = raw;
        bus.ack_i     = ($urandom_range(0, 2) == 0);
        bus.ack_id_i  = ($urandom_range(0, 2) != 0) ? lowest(m_pend & bus.cfg_en_i)
                                                     : IDW'($urandom_range(0, NUM_CH - 1));
        bus.ovf_clr_i = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 29) == 0) begin
            idx = int'($urandom_range(0, NUM_CH - 1));
            bus.cfg_en_i[idx] = ~bus.cfg_en_i[idx];
        end
    endtask

    task automatic pushExpected();
        exp_t e;
        e.pending  = m_pend;
        e.overflow = m_ovf;
        e.irq      = |(m_pend & bus.cfg_en_i);
        e.id       = lowest(m_pend & bus.cfg_en_i);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, actual, required);
        end
    endtask

    task automatic tick(input bit hold_rst);
        @(posedge clk);
        if (!rst) modelStep();
        #1;
        if (hold_rst) begin
            rst = 1'b1;
            modelReset();
        end else begin
            rst = 1'b0;
        end
        applyStimulus();
        pushExpected();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("pending_o",  32'(bus.pending_o),  32'(e.pending));
                checkOutput("overflow_o", 32'(bus.overflow_o), 32'(e.overflow));
                checkOutput("irq_o",      32'(bus.irq_o),      32'(e.irq));
                checkOutput("irq_id_o",   32'(bus.irq_id_o),   32'(e.id));
            end
        end
    end

    initial begin : stimulus
        bus.irq_raw_i        = '0;
        bus.cfg_active_low_i = '0;
        bus.cfg_level_mode_i = '0;
        bus.cfg_en_i         = '0;
        bus.ack_i            = 1'b0;
        bus.ack_id_i         = '0;
        bus.ovf_clr_i        = 1'b0;
        quiet = 1'b1;
        modelReset();
        for (int c = 0; c < NUM_CH; c++) hold_left[c] = 0;

        $display("[TB] idle-high active-low lines through reset release");
        tick(1'b1);
        bus.irq_raw_i        = '1;
        bus.cfg_active_low_i = '1;
        bus.cfg_en_i         = '1;
        repeat (4) tick(1'b1);
        repeat (50) tick(1'b0);

        quiet = 1'b0;
        for (int p = 0; p < 8; p++) begin
            $display("[TB] random phase %0d", p);
            tick(1'b1);
            bus.cfg_active_low_i = NUM_CH'($urandom);
            bus.cfg_level_mode_i = NUM_CH'($urandom);
            bus.cfg_en_i         = NUM_CH'($urandom);
            bus.irq_raw_i        = bus.cfg_active_low_i;
            for (int c = 0; c < NUM_CH; c++) hold_left[c] = int'($urandom_range(10, 30));
            repeat ($urandom_range(2, 4)) tick(1'b1);
            repeat (400) tick(1'b0);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
